// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window generator.
// Window index i maps to output Pi: rows top (oldest) to bottom, columns left to right.
package sobel_pkg;

    localparam int DEFAULT_PIX_W = 8;
    localparam int DEFAULT_IMG_W = 128;
    localparam int DEFAULT_IMG_H = 128;

    typedef logic [DEFAULT_PIX_W-1:0] pixel_t;
    typedef pixel_t [8:0]             window_t;

    localparam int WIN_N      = 9;
    localparam int WIN_P0     = 0;
    localparam int WIN_P1     = 1;
    localparam int WIN_P2     = 2;
    localparam int WIN_P3     = 3;
    localparam int WIN_P4     = 4;
    localparam int WIN_P5     = 5;
    localparam int WIN_P6     = 6;
    localparam int WIN_P7     = 7;
    localparam int WIN_P8     = 8;
    localparam int WIN_CENTER = WIN_P4;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage, combinational read and synchronous write at the same
// address, so a write returns the previous contents in the same cycle (read-before-write).
module sobel_line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[addr_i];

    // NOTE: the storage array has no reset; rows 0 and 1 of every frame overwrite it
    // before any emitted window can observe it, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator for a raster pixel stream.
// Optional macro WIN_COORD_EN adds out_x/out_y (centre pixel coordinates).
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEFAULT_IMG_W,
    parameter int IMG_H = DEFAULT_IMG_H,
    parameter int PIX_W = DEFAULT_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_sof,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         P0,
    output logic [PIX_W-1:0]         P1,
    output logic [PIX_W-1:0]         P2,
    output logic [PIX_W-1:0]         P3,
    output logic [PIX_W-1:0]         P4,
    output logic [PIX_W-1:0]         P5,
    output logic [PIX_W-1:0]         P6,
    output logic [PIX_W-1:0]         P7,
    output logic [PIX_W-1:0]         P8,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
`endif
    output logic                     frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0]    x_q, x_d, cur_x;
    logic [YW-1:0]    y_q, y_d, cur_y;
    logic             emit, last_win;
    logic             valid_q, done_q;
    logic [PIX_W-1:0] line1_rd, line2_rd;
    logic [PIX_W-1:0] win_q [WIN_N];
    logic [PIX_W-1:0] win_d [WIN_N];

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cur_x = in_sof ? '0 : x_q;
        cur_y = in_sof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (in_valid) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    assign emit     = in_valid && (cur_x >= X_TWO) && (cur_y >= Y_TWO);
    assign last_win = in_valid && (cur_x == X_LAST) && (cur_y == Y_LAST);

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_line1 (
        .clk       (clk),
        .addr_i    (cur_x),
        .we_i      (in_valid),
        .wr_data_i (in_data),
        .rd_data_o (line1_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_line2 (
        .clk       (clk),
        .addr_i    (cur_x),
        .we_i      (in_valid),
        .wr_data_i (line1_rd),
        .rd_data_o (line2_rd)
    );

    // Each row shifts left; the new column enters on the right as {line2, line1, pixel}.
    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            win_d[WIN_P0] = win_q[WIN_P1];
            win_d[WIN_P1] = win_q[WIN_P2];
            win_d[WIN_P2] = line2_rd;
            win_d[WIN_P3] = win_q[WIN_P4];
            win_d[WIN_P4] = win_q[WIN_P5];
            win_d[WIN_P5] = line1_rd;
            win_d[WIN_P6] = win_q[WIN_P7];
            win_d[WIN_P7] = win_q[WIN_P8];
            win_d[WIN_P8] = in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= emit;
            done_q  <= last_win;
            win_q   <= win_d;
        end
    end

`ifdef WIN_COORD_EN
    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (emit) begin
            cx_q <= cur_x - 1'b1;
            cy_q <= cur_y - 1'b1;
        end
    end

    assign out_x = cx_q;
    assign out_y = cy_q;
`endif

    assign out_valid  = valid_q;
    assign frame_done = done_q;
    assign P0 = win_q[WIN_P0];
    assign P1 = win_q[WIN_P1];
    assign P2 = win_q[WIN_P2];
    assign P3 = win_q[WIN_P3];
    assign P4 = win_q[WIN_P4];
    assign P5 = win_q[WIN_P5];
    assign P6 = win_q[WIN_P6];
    assign P7 = win_q[WIN_P7];
    assign P8 = win_q[WIN_P8];

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits upstream of the Sobel `Gradient` core. It accepts 8-bit grayscale pixels in raster order, one per cycle, and buffers the two previous image lines. For every interior pixel it presents the full neighbourhood `P0..P8` plus a valid strobe, so that `Gradient` can produce the edge bit `Dop`.

## Interface
- `IMG_W`, default 128: pixels per line; must be at least 3.
- `IMG_H`, default 128: lines per frame; must be at least 3.
- `PIX_W`, default 8: pixel width; must match `Gradient` inputs.
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` carries a pixel this cycle.
- `in_data` input, `PIX_W` bits: pixel in raster order.
- `in_sof` input, 1 bit: start of frame. Qualified by `in_valid`; marks the pixel at (0,0).
- `out_valid` output, 1 bit: window outputs are valid this cycle.
- `P0`..`P8` output, `PIX_W` bits each: the 3x3 window.
  - `P0 P1 P2` is the top (oldest) row, left to right.
  - `P3 P4 P5` is the middle row; `P4` is the centre.
  - `P6 P7 P8` is the bottom (newest) row.
- `frame_done` output, 1 bit: one-cycle pulse on the window that completes a frame.
- `out_x`, `out_y` output, `$clog2(IMG_W)` / `$clog2(IMG_H)` bits: coordinates of the centre pixel. Present only under `WIN_COORD_EN`.

## Operation
- **Counters.** Column counter `x` runs 0..IMG_W-1 and row counter `y` runs 0..IMG_H-1. They advance only on accepted pixels (`in_valid`=1).
  - `x` wraps to 0 and increments `y`.
  - After (IMG_W-1, IMG_H-1) both counters wrap to 0.
- **Line buffers.** Two buffers, each IMG_W deep, hold rows y-1 and y-2.
  - They are addressed by `x`, with read-before-write on each accepted pixel.
  - The new pixel is written to line1, and the old line1 value is written to line2.
- **Window shift.** Three 3-deep column shift registers take `{line2[x], line1[x], in_data}` on each accepted pixel.
- **Window emission.** A window is emitted when the accepted pixel is at (x,y) with x>=2 and y>=2.
  - Its centre is (x-1, y-1). Border pixels never produce windows.
  - Exactly (IMG_W-2)*(IMG_H-2) windows are produced per frame.
- **Wrapped columns.** At x=0 and x=1 the shift registers hold pixels from the previous line. No window is emitted for them.
- **Input gaps.** `in_valid`=0 holds all state. `out_valid` is 0 in the following cycle.
- **Start of frame.** `in_sof`=1 with `in_valid`=1 treats that pixel as (0,0) whatever the counters hold. A partial frame is abandoned without `frame_done`.
  - `in_sof` with `in_valid`=0 is ignored.
- **Frame completion.** `frame_done` is 1 together with `out_valid` for the window centred at (IMG_W-2, IMG_H-2).
- **Data path.** There is no backpressure and no arithmetic on pixel values; they pass through unmodified.

## Timing
- **Latency.** `out_valid` and the window registers update on the clock edge that accepts the qualifying pixel, so outputs are visible the next cycle.
- **Throughput.** One window per cycle, sustained.
- **Reset values.**
  - `out_valid`, `frame_done`, `P0..P8`, `out_x`, `out_y`: 0.
  - `x`, `y`: 0.
  - Line buffer contents are not reset. They are never observed before being overwritten, because rows 0 and 1 emit nothing.
- **Reset mid-frame.** Outputs go to 0 asynchronously. The first pixel after reset is taken as (0,0).
- **Line buffer timing.** Buffer read data must be available in the same cycle as `in_data`. Either use a combinational read, or pre-read address x one cycle early and hold it across gaps.

## Configuration
- `WIN_COORD_EN` defined: ports `out_x`/`out_y` exist. They are registered with the window and reset to 0.
- `WIN_COORD_EN` not defined: the ports and their registers are absent. The window and `out_valid` behaviour is identical in both builds.

## Structure
- **Package `sobel_pkg`:**
  - `PIX_W` default.
  - `pixel_t` typedef.
  - `window_t` (array of 9 `pixel_t`).
  - Localparams for window indices, `WIN_CENTER`=4.
  - Default `IMG_W`/`IMG_H`.
- **Sub-module `sobel_line_buffer`:** one line of IMG_W x PIX_W with read-before-write at a single address. It is instantiated twice.

## Test plan
- **Ramp frame.** IMG_W=IMG_H=4, pixel = 16*y+x, continuous `in_valid` with `in_sof` on the first pixel.
  - Exactly 4 windows.
  - First window: P0..P8 = 00,01,02,10,11,12,20,21,22, centre (1,1).
  - Last window: P0..P8 = 11,12,13,21,22,23,31,32,33 with `frame_done`=1.
- **Input gaps.** Same frame with `in_valid` low every other cycle. The same 4 windows are produced in the same order, and `out_valid` is never high in the cycle after a gap.
- **Back-to-back frames.** Frame 2 = frame 1 + 0x40.
  - No window is emitted for frame-2 rows 0..1.
  - The first frame-2 window has P4=0x51.
- **SOF mid-frame.** `in_sof` asserted at pixel (1,2) of frame 1, then a full ramp frame.
  - No `frame_done` for the abandoned frame.
  - The new frame yields exactly 4 correct windows.
- **Reset mid-frame.** `rst_n` is pulsed low after 9 pixels.
  - All outputs read 0 during reset.
  - A subsequent full ramp frame produces the 4 reference windows.
- **Gradient pairing.** Connect to `Gradient` with T=20 and a frame whose left two columns are 0 and the rest 200. `Dop`=1 only for windows whose centre is at x=1 or x=2.
